ff_bank_multimode: RTL

//  Parametrised bank of WIDTH flip-flops sharing one clock. A runtime mode input

---
 rtl/ff_bank_pkg.sv | 47 ++++
 rtl/ff_cell.sv | 48 ++++
 rtl/ff_bank_multimode.sv | 80 ++++++++
 3 files changed

// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg
//  Shared definitions for the multimode flip-flop bank.
//  - MODE_* : runtime interpretation of the J/K inputs.
//  - next_bit(mode, j, k, q) : single-bit next-state function, returns
//    {q_next, illegal}. illegal is set only for the SR-mode S=R=1 case.
package ff_bank_pkg;

  localparam logic [1:0] MODE_JK = 2'd0;
  localparam logic [1:0] MODE_SR = 2'd1;
  localparam logic [1:0] MODE_D  = 2'd2;
  localparam logic [1:0] MODE_T  = 2'd3;

  function automatic logic [1:0] next_bit(
    input logic [1:0] mode,
    input logic       j,
    input logic       k,
    input logic       q
  );
    logic qn;
    logic ill;
    qn  = q;
    ill = 1'b0;
    case (mode)
      MODE_JK: begin
        case ({j, k})
          2'b01:   qn = 1'b0;
          2'b10:   qn = 1'b1;
          2'b11:   qn = ~q;
          default: qn = q;
        endcase
      end
      MODE_SR: begin
        case ({j, k})
          2'b01:   qn = 1'b0;
          2'b10:   qn = 1'b1;
          // S=R=1 holds the bit and reports the illegal combination.
          2'b11:   ill = 1'b1;
          default: qn = q;
        endcase
      end
      MODE_D:  qn = j;
      default: qn = q ^ j;  // MODE_T
    endcase
    return {qn, ill};
  endfunction

endpackage

// File: rtl/ff_cell.sv
// ff_cell
//  One bit of the multimode flip-flop bank, plus its sticky SR-illegal flag.
//  Ports:
//    clk, rst      clock / asynchronous active-high reset
//    en            update enable (0 = hold, sr_err not set)
//    mode          MODE_JK / MODE_SR / MODE_D / MODE_T
//    j, k          data inputs
//    err_clr       clears sr_err at the next edge (a new illegal wins)
//    q             registered state, reset to RST_BIT
//    sr_err        sticky SR S=R=1 flag
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  input  logic       err_clr,
  output logic       q,
  output logic       sr_err
);

  logic [1:0] nb;

  assign nb = next_bit(mode, j, k, q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= RST_BIT;
      sr_err <= 1'b0;
    end else begin
      if (en) begin
        q <= nb[1];
      end
      // A fresh illegal condition takes priority over the clear.
      if (en && nb[0]) begin
        sr_err <= 1'b1;
      end else if (err_clr) begin
        sr_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ff_bank_multimode.sv
// ff_bank_multimode
//  Bank of WIDTH flip-flops sharing one clock; mode selects JK, SR, D or T
//  interpretation of J/K. Provides per-bit sticky SR-illegal flags and a
//  saturating count of enabled edges on which Q changed.
//  Ports:
//    clk, rst   clock / asynchronous active-high reset
//    en         update enable
//    mode       0=JK 1=SR 2=D 3=T
//    J, K       per-bit inputs (K ignored in D and T modes)
//    err_clr    clears sr_err at next edge
//    cnt_clr    clears chg_cnt at next edge (drops that edge's increment)
//    Q, Q_bar   registered state and its complement
//    sr_err     sticky per-bit SR illegal flags
//    chg_cnt    saturating change counter
module ff_bank_multimode
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic [WIDTH-1:0] sr_err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] chg_bits;
  logic             changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .j       (J[i]),
      .k       (K[i]),
      .err_clr (err_clr),
      .q       (Q[i]),
      .sr_err  (sr_err[i])
    );
  end

  // Per-bit change detect: only the q_next half of next_bit() is compared,
  // the illegal half is masked off.
  always_comb begin
    chg_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      chg_bits[i] = (next_bit(mode, J[i], K[i], Q[i]) & 2'b10) != {Q[i], 1'b0};
    end
  end

  assign changed = en && (|chg_bits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt <= '0;
    end else if (cnt_clr) begin
      chg_cnt <= '0;
    end else if (changed && (chg_cnt != CNT_MAX)) begin
      chg_cnt <= chg_cnt + 1'b1;
    end
  end

  assign Q_bar = ~Q;

endmodule
